// File: rtl/bram_to_axis.sv
// bram_to_axis: streams BRAM words 0..i_num_cnt-1 (1-cycle read latency) as an AXI4-Stream master, TLAST on the final beat.
// Latency: i_run edge -> ce/addr 0 next cycle -> q one cycle later -> tvalid with word 0 three cycles after i_run; 1 beat/cycle sustained.
// Backpressure: reads are throttled so FIFO entries + in-flight read never exceed FIFO depth; tready low stalls without loss.
//
// Ports: clk/reset_n (async active-low); i_run/i_num_cnt start a transfer from S_IDLE;
//        o_idle/o_running/o_done state flags; addr/ce/we/d/q BRAM read port (we and d tied 0);
//        m_axis_tvalid/tready/tdata/tlast stream output.
// Optional: define BRAM2AXIS_STALL_CNT_EN to add o_stall_cnt[31:0], a saturating count of
//           S_RUN cycles with tvalid=1 and tready=0 (cleared on accepted i_run).
module bram_to_axis #(
  parameter int CNT_BIT     = 31,
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 12,
  parameter int FIFO_AWIDTH = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_run,
  input  logic [CNT_BIT-1:0] i_num_cnt,
  output logic               o_idle,
  output logic               o_running,
  output logic               o_done,
  output logic [AWIDTH-1:0]  addr,
  output logic               ce,
  output logic               we,
  output logic [DWIDTH-1:0]  d,
  input  logic [DWIDTH-1:0]  q,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [DWIDTH-1:0]  m_axis_tdata,
  output logic               m_axis_tlast
`ifdef BRAM2AXIS_STALL_CNT_EN
  ,
  output logic [31:0]        o_stall_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_AWIDTH;
  localparam logic [FIFO_AWIDTH+1:0] DEPTH_W = (FIFO_AWIDTH+2)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_BIT-1:0]     num_cnt_q, num_cnt_d;
  logic [CNT_BIT-1:0]     rd_cnt_q, rd_cnt_d;
  logic [CNT_BIT-1:0]     beat_cnt_q, beat_cnt_d;
  logic                   inflight_q, inflight_d;
  logic [FIFO_AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AWIDTH:0]   fifo_cnt_q, fifo_cnt_d;
  logic [DWIDTH-1:0]      mem_q [DEPTH];
  logic [DWIDTH-1:0]      mem_d [DEPTH];

  logic                   push, pop, last_hs, ce_w;
  logic [FIFO_AWIDTH+1:0] occ;

  assign o_idle        = (state_q == S_IDLE);
  assign o_running     = (state_q == S_RUN);
  assign o_done        = (state_q == S_DONE);
  assign we            = 1'b0;
  assign d             = '0;
  assign addr          = rd_cnt_q[AWIDTH-1:0];
  assign ce            = ce_w;
  assign m_axis_tvalid = (fifo_cnt_q != '0);
  assign m_axis_tdata  = mem_q[rd_ptr_q];
  // tvalid gate keeps num_cnt-1 underflow at num_cnt=0 harmless
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == num_cnt_q - CNT_BIT'(1));

  assign push    = inflight_q;
  assign pop     = m_axis_tvalid && m_axis_tready;
  assign last_hs = pop && m_axis_tlast;
  // Occupancy counts the read still in the BRAM pipe so its data always has a slot
  assign occ     = {1'b0, fifo_cnt_q} + {{(FIFO_AWIDTH+1){1'b0}}, inflight_q};
  assign ce_w    = (state_q == S_RUN) && (rd_cnt_q < num_cnt_q) && (occ < DEPTH_W);

  always_comb begin
    state_d    = state_q;
    num_cnt_d  = num_cnt_q;
    rd_cnt_d   = rd_cnt_q + CNT_BIT'(ce_w);
    beat_cnt_d = beat_cnt_q + CNT_BIT'(pop);
    inflight_d = ce_w;
    wr_ptr_d   = push ? wr_ptr_q + FIFO_AWIDTH'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + FIFO_AWIDTH'(1) : rd_ptr_q;
    mem_d      = mem_q;
    if (push) mem_d[wr_ptr_q] = q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + (FIFO_AWIDTH+1)'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - (FIFO_AWIDTH+1)'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          state_d    = S_RUN;
          num_cnt_d  = i_num_cnt;
          rd_cnt_d   = '0;
          beat_cnt_d = '0;
        end
      end
      S_RUN: begin
        // zero-length transfer spends exactly one cycle here
        if (last_hs || (num_cnt_q == '0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d   = S_IDLE;
        num_cnt_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      num_cnt_q  <= '0;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      mem_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      num_cnt_q  <= num_cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      mem_q      <= mem_d;
    end
  end

`ifdef BRAM2AXIS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign o_stall_cnt = stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == S_IDLE) && i_run) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_RUN) && m_axis_tvalid && !m_axis_tready &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end
`endif

endmodule

// File: tb/tb_bram_to_axis.sv
module tb_bram_to_axis;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_run;
  logic [30:0] i_num_cnt;
  logic        o_idle, o_running, o_done;
  logic [11:0] addr;
  logic        ce, we;
  logic [31:0] d, q;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [31:0] m_axis_tdata;
`ifdef BRAM2AXIS_STALL_CNT_EN
  logic [31:0] o_stall_cnt;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  bram_to_axis dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_run         (i_run),
    .i_num_cnt     (i_num_cnt),
    .o_idle        (o_idle),
    .o_running     (o_running),
    .o_done        (o_done),
    .addr          (addr),
    .ce            (ce),
    .we            (we),
    .d             (d),
    .q             (q),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast)
`ifdef BRAM2AXIS_STALL_CNT_EN
    ,
    .o_stall_cnt   (o_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: 1-cycle read latency
  logic [31:0] bram [0:4095];
  always @(posedge clk) if (ce) q <= bram[addr];

  // Stream monitor: records accepted beats, ce pulses and AXI hold-rule violations
  logic [31:0] bq[$];
  logic        lq[$];
  int          ce_cnt = 0;
  int          tv_cnt = 0;
  int          viol   = 0;
  logic        hold   = 1'b0;
  logic [31:0] hold_dat;

  always @(posedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (ce) ce_cnt = ce_cnt + 1;
      if (m_axis_tvalid) tv_cnt = tv_cnt + 1;
      if (m_axis_tvalid && m_axis_tready) begin
        bq.push_back(m_axis_tdata);
        lq.push_back(m_axis_tlast);
      end
      if (hold && (!m_axis_tvalid || m_axis_tdata !== hold_dat)) viol = viol + 1;
      hold     = m_axis_tvalid && !m_axis_tready;
      hold_dat = m_axis_tdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    bq.delete();
    lq.delete();
    ce_cnt = 0;
    tv_cnt = 0;
  endtask

  // called at a negedge; returns at the next negedge (cycle 1 of the transfer)
  task automatic start(input logic [30:0] n);
    i_num_cnt = n;
    i_run     = 1'b1;
    @(negedge clk);
    i_run     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!o_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done"}, o_done, 1);
  endtask

  // beats must be base, base+1, ... in order, tlast only on the final one
  task automatic check_seq(input string tag, input int n, input logic [31:0] base);
    int bad = 0;
    chk({tag, "_beats"}, bq.size(), n);
    for (int i = 0; i < bq.size(); i++) begin
      if (bq[i] !== base + 32'(i)) bad++;
      if (lq[i] !== (i == n - 1)) bad++;
    end
    chk({tag, "_order_last"}, bad, 0);
  endtask

  initial begin
    for (int k = 0; k < 4096; k++) bram[k] = 32'h100 + 32'(k);
    reset_n       = 1'b0;
    i_run         = 1'b0;
    i_num_cnt     = '0;
    m_axis_tready = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_tvalid",  m_axis_tvalid, 0);
    chk("rst_tlast",   m_axis_tlast, 0);
    chk("rst_tdata",   m_axis_tdata, 0);
    chk("rst_ce",      ce, 0);
    chk("rst_addr",    addr, 0);
    chk("rst_done",    o_done, 0);
    chk("rst_running", o_running, 0);
    chk("rst_idle",    o_idle, 1);
    chk("rst_we",      we, 0);
    chk("rst_d",       d, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // ---- full throughput, 16 words ----
    clear_mon();
    m_axis_tready = 1'b1;
    start(16);
    chk("tp_running_c1", o_running, 1);
    chk("tp_ce_c1",      ce, 1);
    chk("tp_addr_c1",    addr, 0);
    @(negedge clk);
    chk("tp_tvalid_c2",  m_axis_tvalid, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("tp_tvalid_%0d", i), m_axis_tvalid, 1);
      chk($sformatf("tp_tdata_%0d", i),  m_axis_tdata, 32'h100 + 32'(i));
      chk($sformatf("tp_tlast_%0d", i),  m_axis_tlast, (i == 15));
    end
    @(negedge clk);
    chk("tp_done",        o_done, 1);
    chk("tp_tvalid_done", m_axis_tvalid, 0);
    @(negedge clk);
    chk("tp_done_pulse",  o_done, 0);
    chk("tp_idle",        o_idle, 1);
    check_seq("tp", 16, 32'h100);

    // ---- backpressure, 10 words ----
    clear_mon();
    m_axis_tready = 1'b0;
    start(10);
    repeat (2) @(negedge clk);
    chk("bp_tvalid_c3", m_axis_tvalid, 1);
    chk("bp_tdata_c3",  m_axis_tdata, 32'h100);
    begin
      int bad = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!m_axis_tvalid || m_axis_tdata !== 32'h100) bad++;
      end
      chk("bp_hold_stable", bad, 0);
    end
    chk("bp_ce_pulses", ce_cnt, 4);
    begin
      int n = 0;
      while (!o_done && n < 400) begin
        m_axis_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        n++;
      end
    end
    m_axis_tready = 1'b1;
    chk("bp_done", o_done, 1);
    check_seq("bp", 10, 32'h100);
    chk("bp_ce_total", ce_cnt, 10);
    @(negedge clk);

    // ---- single word ----
    clear_mon();
    start(1);
    wait_done("single");
    check_seq("single", 1, 32'h100);
    @(negedge clk);
    chk("single_done_pulse", o_done, 0);
    chk("single_idle",       o_idle, 1);

    // ---- zero count ----
    clear_mon();
    start(0);
    chk("zero_running", o_running, 1);
    chk("zero_ce",      ce, 0);
    @(negedge clk);
    chk("zero_done",    o_done, 1);
    @(negedge clk);
    chk("zero_idle",    o_idle, 1);
    chk("zero_ce_cnt",  ce_cnt, 0);
    chk("zero_tv_cnt",  tv_cnt, 0);

    // ---- i_run during S_RUN is ignored ----
    clear_mon();
    start(5);
    @(negedge clk);
    i_num_cnt = 31'd20;
    i_run     = 1'b1;
    @(negedge clk);
    i_run     = 1'b0;
    wait_done("ign");
    check_seq("ign", 5, 32'h100);
    @(negedge clk);
    chk("ign_idle", o_idle, 1);
    @(negedge clk);
    chk("ign_no_restart", o_running, 0);

    // ---- reset mid-transfer ----
    clear_mon();
    start(8);
    repeat (5) @(negedge clk);
    chk("mr_beat4_tdata", m_axis_tdata, 32'h103);
    reset_n = 1'b0;
    #1;
    chk("mr_tvalid", m_axis_tvalid, 0);
    chk("mr_idle",   o_idle, 1);
    chk("mr_ce",     ce, 0);
    chk("mr_tdata",  m_axis_tdata, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_mon();
    start(8);
    chk("mr_addr_restart", addr, 0);
    chk("mr_ce_restart",   ce, 1);
    wait_done("mr");
    check_seq("mr", 8, 32'h100);
    @(negedge clk);

`ifdef BRAM2AXIS_STALL_CNT_EN
    // ---- stall counter ----
    clear_mon();
    m_axis_tready = 1'b0;
    start(4);
    repeat (2) @(negedge clk);
    chk("st_tvalid", m_axis_tvalid, 1);
    repeat (7) @(negedge clk);
    m_axis_tready = 1'b1;
    wait_done("st");
    chk("st_cnt_done", o_stall_cnt, 7);
    @(negedge clk);
    chk("st_cnt_hold", o_stall_cnt, 7);
    check_seq("st", 4, 32'h100);
`endif

    chk("axis_hold_violations", viol, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
